conv_tap_sequencer: RTL and testbench

//  Sequences one conv output pixel through the shared MAC datapath: walks KSIZE*KSIZE taps
//  (tap fastest, then channel) over cfg_num_ch input channels, one MAC op per accepted input

---
 rtl/conv_tap_sequencer_pkg.sv | 25 ++
 rtl/conv_tap_sequencer_if.sv | 31 +++
 rtl/conv_tap_sequencer_wrap_counter.sv | 28 ++
 rtl/conv_tap_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_conv_tap_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/conv_tap_sequencer_pkg.sv
// Shared definitions for the conv pixel datapath: sequencer state set, default
// geometry, and width helpers used by the sequencer, MAC array and line buffer.
package conv_pkg;

  localparam int unsigned KSIZE_DEF   = 3;
  localparam int unsigned MAX_CH_DEF  = 16;
  localparam int unsigned MAC_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  // Width of a tap index; never narrower than one bit.
  function automatic int unsigned tap_w(input int unsigned ksize);
    return (ksize * ksize > 1) ? $clog2(ksize * ksize) : 1;
  endfunction

  // Width of a channel count (must hold MAX_CH itself).
  function automatic int unsigned ch_w(input int unsigned max_ch);
    return $clog2(max_ch) + 1;
  endfunction

endpackage

// File: rtl/conv_tap_sequencer_if.sv
// Handshake/control bundle between the line-buffer feeder (master) and the
// tap sequencer (slave), including the MAC-array control outputs.
//   start/cfg_num_ch/abort/in_valid : feeder -> sequencer
//   in_ready, mac_*, out_valid, busy: sequencer -> feeder / MAC array
interface conv_tap_sequencer_if #(
  parameter int unsigned TAP_W = 4,
  parameter int unsigned CH_W  = 5
);
  logic             start;
  logic [CH_W-1:0]  cfg_num_ch;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic             mac_en;
  logic             mac_clr;
  logic             mac_last;
  logic [TAP_W-1:0] mac_tap;
  logic [CH_W-1:0]  mac_ch;
  logic             out_valid;
  logic             busy;

  modport master (
    output start, cfg_num_ch, abort, in_valid,
    input  in_ready, mac_en, mac_clr, mac_last, mac_tap, mac_ch, out_valid, busy
  );

  modport slave (
    input  start, cfg_num_ch, abort, in_valid,
    output in_ready, mac_en, mac_clr, mac_last, mac_tap, mac_ch, out_valid, busy
  );
endinterface

// File: rtl/conv_tap_sequencer_wrap_counter.sv
// conv_wrap_counter: modulo counter with enable and synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   en         : advance by one (wraps modulus-1 -> 0)
//   clr        : synchronous clear, wins over en
//   modulus    : wrap modulus (W+1 bits so 2**W is representable)
//   value      : current count
//   term_c     : combinational, value == modulus-1
module conv_wrap_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W:0]   modulus,
  output logic [W-1:0] value,
  output logic         term_c
);

  assign term_c = ({1'b0, value} == (modulus - (W+1)'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      value <= '0;
    else if (clr)    value <= '0;
    else if (en)     value <= term_c ? '0 : value + W'(1);
  end

endmodule

// File: rtl/conv_tap_sequencer.sv
// conv_tap_sequencer: steps one output pixel through the shared MAC datapath,
// tap fastest then channel, one MAC op per accepted beat, then waits out the
// MAC pipeline and pulses out_valid.
//   clk, rst_n : clock, async active-low reset
//   bus        : conv_tap_sequencer_if.slave (start/cfg/abort/in_valid in;
//                in_ready, mac_en/clr/last/tap/ch, out_valid, busy out)
//   stall_cnt  : RUN cycles without in_valid (only with CONV_SEQ_PERF_EN)
// Optional feature macro: CONV_SEQ_PERF_EN
module conv_tap_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned KSIZE   = KSIZE_DEF,
  parameter int unsigned MAX_CH  = MAX_CH_DEF,
  parameter int unsigned MAC_LAT = MAC_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_tap_sequencer_if.slave  bus
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int unsigned KK    = KSIZE * KSIZE;
  localparam int unsigned TAP_W = tap_w(KSIZE);
  localparam int unsigned CH_W  = ch_w(MAX_CH);
  localparam int unsigned DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_RUN   = 2'(RUN);
  localparam logic [1:0] S_DRAIN = 2'(DRAIN);

  logic [1:0]       state_q, state_d;
  logic [CH_W-1:0]  num_ch_q, num_ch_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             mac_en_q, mac_en_d;
  logic             mac_clr_q, mac_clr_d;
  logic             mac_last_q, mac_last_d;
  logic [TAP_W-1:0] mac_tap_q, mac_tap_d;
  logic [CH_W-1:0]  mac_ch_q, mac_ch_d;
  logic             out_valid_q, out_valid_d;

  logic [TAP_W-1:0] tap_val;
  logic [CH_W-1:0]  ch_val;
  logic             tap_term_c, ch_term_c;
  logic             start_acc_c, abort_c, beat_c, final_c, cnt_clr_c;

  // Abort outranks a same-cycle beat, so a beat only counts when abort is low.
  assign start_acc_c = (state_q == S_IDLE) && bus.start;
  assign abort_c     = (state_q != S_IDLE) && bus.abort;
  assign beat_c      = (state_q == S_RUN) && in_ready_q && bus.in_valid && !bus.abort;
  assign final_c     = beat_c && tap_term_c && ch_term_c;
  assign cnt_clr_c   = start_acc_c || abort_c;

  conv_wrap_counter #(.W(TAP_W)) u_tap_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (beat_c),
    .clr     (cnt_clr_c),
    .modulus ((TAP_W+1)'(KK)),
    .value   (tap_val),
    .term_c  (tap_term_c)
  );

  conv_wrap_counter #(.W(CH_W)) u_ch_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (beat_c && tap_term_c),
    .clr     (cnt_clr_c),
    .modulus ({1'b0, num_ch_q}),
    .value   (ch_val),
    .term_c  (ch_term_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    num_ch_d    = num_ch_q;
    drn_d       = drn_q;
    in_ready_d  = 1'b0;
    mac_en_d    = 1'b0;
    mac_clr_d   = 1'b0;
    mac_last_d  = 1'b0;
    mac_tap_d   = mac_tap_q;
    mac_ch_d    = mac_ch_q;
    out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.cfg_num_ch == '0)                num_ch_d = CH_W'(1);
          else if (bus.cfg_num_ch > CH_W'(MAX_CH)) num_ch_d = CH_W'(MAX_CH);
          else                                     num_ch_d = bus.cfg_num_ch;
          state_d    = S_RUN;
          in_ready_d = 1'b1;
        end
      end
      S_RUN: begin
        in_ready_d = 1'b1;
        if (beat_c) begin
          mac_en_d  = 1'b1;
          mac_tap_d = tap_val;
          mac_ch_d  = ch_val;
          mac_clr_d = (tap_val == '0) && (ch_val == '0);
          if (final_c) begin
            mac_last_d = 1'b1;
            in_ready_d = 1'b0;
            drn_d      = '0;
            state_d    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // drn_q counts cycles since the mac_last cycle.
        if (out_valid_q) begin
          state_d = S_IDLE;
          drn_d   = '0;
        end else begin
          drn_d = drn_q + DRN_W'(1);
          if (drn_q == DRN_W'(MAC_LAT - 1)) out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_c) begin
      state_d     = S_IDLE;
      drn_d       = '0;
      in_ready_d  = 1'b0;
      mac_en_d    = 1'b0;
      mac_clr_d   = 1'b0;
      mac_last_d  = 1'b0;
      mac_tap_d   = '0;
      mac_ch_d    = '0;
      out_valid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      num_ch_q    <= '0;
      drn_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_last_q  <= 1'b0;
      mac_tap_q   <= '0;
      mac_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_ch_q    <= num_ch_d;
      drn_q       <= drn_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      mac_en_q    <= mac_en_d;
      mac_clr_q   <= mac_clr_d;
      mac_last_q  <= mac_last_d;
      mac_tap_q   <= mac_tap_d;
      mac_ch_q    <= mac_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.mac_en    = mac_en_q;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.mac_last  = mac_last_q;
  assign bus.mac_tap   = mac_tap_q;
  assign bus.mac_ch    = mac_ch_q;
  assign bus.out_valid = out_valid_q;

`ifdef CONV_SEQ_PERF_EN
  logic [15:0] stall_q;

  // Saturating count of RUN cycles the feeder left empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 stall_q <= '0;
    else if (start_acc_c)       stall_q <= '0;
    else if ((state_q == S_RUN) && !bus.in_valid && (stall_q != 16'hFFFF))
                                stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Self-checking bench for conv_tap_sequencer with default geometry
// (KSIZE=3, MAX_CH=16, MAC_LAT=2). The reference derives every expected op
// from its position in the pixel: op i -> tap i%9, channel i/9.
module tb_conv_tap_sequencer;
  import conv_pkg::*;

  localparam int unsigned TAP_W = tap_w(KSIZE_DEF);
  localparam int unsigned CH_W  = ch_w(MAX_CH_DEF);
  localparam int          KK    = int'(KSIZE_DEF * KSIZE_DEF);
  localparam int          LAT   = int'(MAC_LAT_DEF);

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  conv_tap_sequencer_if #(.TAP_W(TAP_W), .CH_W(CH_W)) bus ();

`ifdef CONV_SEQ_PERF_EN
  logic [15:0] stall_cnt;
`endif

  conv_tap_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CONV_SEQ_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected MAC-side outputs for op number idx of a pixel with total ops.
  task automatic check_mac(input bit en, input int idx, input int total);
    chk("mac_en", 32'(bus.mac_en), 32'(en));
    if (en) begin
      chk("mac_tap",  32'(bus.mac_tap),  32'(idx % KK));
      chk("mac_ch",   32'(bus.mac_ch),   32'(idx / KK));
      chk("mac_clr",  32'(bus.mac_clr),  32'(idx == 0));
      chk("mac_last", 32'(bus.mac_last), 32'(idx == total - 1));
    end else begin
      chk("mac_clr_idle",  32'(bus.mac_clr),  32'd0);
      chk("mac_last_idle", 32'(bus.mac_last), 32'd0);
    end
  endtask

  // Entered and left at a negedge of an IDLE cycle. pct<0 selects an
  // alternating 1/0 in_valid pattern; abort_at is the accepted-beat count at
  // which abort is raised together with in_valid (-1 = never).
  task automatic run_pixel(input int cfg, input int pct, input int abort_at, input bit poke);
    int  n, total, beats, idx, iter, stalls;
    bit  pend, aborted;
    n = (cfg == 0) ? 1 : ((cfg > int'(MAX_CH_DEF)) ? int'(MAX_CH_DEF) : cfg);
    total = KK * n;
    beats = 0; idx = 0; iter = 0; stalls = 0; pend = 1'b0; aborted = 1'b0;

    bus.start      = 1'b1;
    bus.cfg_num_ch = CH_W'(cfg);
    bus.in_valid   = 1'b1;
    bus.abort      = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;

    while (beats < total && !aborted) begin
      check_mac(pend, idx, total);
      chk("in_ready_run", 32'(bus.in_ready), 32'd1);
      chk("busy_run", 32'(bus.busy), 32'd1);
      chk("out_valid_run", 32'(bus.out_valid), 32'd0);
`ifdef CONV_SEQ_PERF_EN
      chk("stall_cnt_run", 32'(stall_cnt), 32'(stalls));
`endif
      if (iter > 5000) begin
        chk("run_timeout", 32'(beats), 32'(total));
        return;
      end
      bus.in_valid   = (pct < 0) ? (iter % 2 == 0) : (int'($urandom_range(99)) < pct);
      bus.start      = poke & 1'($urandom_range(1));
      bus.cfg_num_ch = CH_W'($urandom_range(31));
      bus.abort      = bus.in_valid && (beats == abort_at);
      if (!bus.in_valid) stalls++;
      aborted = bus.abort;
      pend    = bus.in_valid && !bus.abort;
      if (pend) begin
        idx = beats;
        beats++;
      end
      iter++;
      @(negedge clk);
      bus.abort = 1'b0;
    end

    if (aborted) begin
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      chk("abort_mac_en", 32'(bus.mac_en), 32'd0);
      chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_tap", 32'(bus.mac_tap), 32'd0);
      chk("abort_ch", 32'(bus.mac_ch), 32'd0);
      chk("abort_ov", 32'(bus.out_valid), 32'd0);
      repeat (LAT + 2) begin
        @(negedge clk);
        chk("abort_no_ov", 32'(bus.out_valid), 32'd0);
        chk("abort_idle_busy", 32'(bus.busy), 32'd0);
      end
      return;
    end

    // Cycle c+1: final op issued, no more beats.
    check_mac(1'b1, total - 1, total);
    chk("in_ready_last", 32'(bus.in_ready), 32'd0);
    chk("busy_last", 32'(bus.busy), 32'd1);
    chk("out_valid_last", 32'(bus.out_valid), 32'd0);
    for (int k = 2; k <= LAT + 1; k++) begin
      bus.in_valid = 1'($urandom_range(1));
      bus.start    = poke & 1'($urandom_range(1));
      @(negedge clk);
      chk("drain_mac_en", 32'(bus.mac_en), 32'd0);
      chk("drain_in_ready", 32'(bus.in_ready), 32'd0);
      chk("drain_busy", 32'(bus.busy), 32'd1);
      chk("drain_out_valid", 32'(bus.out_valid), 32'(k == LAT + 1));
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("done_out_valid", 32'(bus.out_valid), 32'd0);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("done_in_ready", 32'(bus.in_ready), 32'd0);
    chk("done_mac_en", 32'(bus.mac_en), 32'd0);
`ifdef CONV_SEQ_PERF_EN
    chk("stall_cnt_held", 32'(stall_cnt), 32'(stalls));
`endif
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.cfg_num_ch = '0;
    bus.abort      = 1'b0;
    bus.in_valid   = 1'b0;
    #3;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_mac_en", 32'(bus.mac_en), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mac_tap", 32'(bus.mac_tap), 32'd0);
`ifdef CONV_SEQ_PERF_EN
    chk("rst_stall", 32'(stall_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE ignores in_valid and abort.
    bus.in_valid = 1'b1;
    bus.abort    = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_mac_en", 32'(bus.mac_en), 32'd0);
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;

    // Single channel, back-to-back beats.
    run_pixel(1, 100, -1, 1'b0);
    // Two channels, alternating in_valid.
    run_pixel(2, -1, -1, 1'b0);
    // Stray start during RUN, then cfg 0 treated as one channel.
    run_pixel(3, 70, -1, 1'b1);
    run_pixel(0, 80, -1, 1'b0);
    // Abort together with the 6th in_valid, then a normal pixel.
    run_pixel(2, 100, 5, 1'b0);
    run_pixel(1, 100, -1, 1'b0);
    // Over-range channel count clamps to MAX_CH.
    run_pixel(31, 90, -1, 1'b0);

    // Reset in the middle of RUN.
    bus.start      = 1'b1;
    bus.cfg_num_ch = CH_W'(2);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_mac_en", 32'(bus.mac_en), 32'd0);
    chk("midrst_mac_tap", 32'(bus.mac_tap), 32'd0);
    chk("midrst_mac_ch", 32'(bus.mac_ch), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    run_pixel(1, 100, -1, 1'b0);

    // Randomised pixels, some with stray starts or aborts.
    for (int p = 0; p < 8; p++) begin
      int cfg, pct, ab;
      cfg = int'($urandom_range(20));
      pct = 30 + int'($urandom_range(70));
      ab  = ($urandom_range(3) == 0) ? int'($urandom_range(8)) : -1;
      run_pixel(cfg, pct, ab, 1'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
